alu_cmd_sequencer: RTL

//  Control stage wrapped around the 5-bit combinational ALU (op=0 XOR, op=1 ROR A by B).

---
 rtl/alu_cmd_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Control stage around a WIDTH-bit combinational ALU (op 0 = XOR, op 1 = ROR A by B).
//   A command is accepted over cmd_valid/cmd_ready and its operands are registered.
//   The ALU is then driven from those registers for one cycle, and R/ZF are captured.
//   The captured result is offered over res_valid/res_ready.
//   In chain mode, the last delivered result replaces operand A.
//   Saturating counters track delivered results and delivered zero results.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/ready/op/a/b/chain   upstream command handshake and payload
//   alu_op/a/b  -> ALU             registered operands
//   alu_r/zf    <- ALU             combinational result and zero flag
//   res_valid/ready/r/zf           downstream result handshake and payload
//   op_count, zero_count           saturating delivery counters
module alu_cmd_sequencer #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic             alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_r,
  output logic             res_zf,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] zero_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             zf_q, zf_d;
  logic [WIDTH-1:0] last_r_q, last_r_d;
  logic             have_last_q, have_last_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    zf_d        = zf_q;
    last_r_d    = last_r_q;
    have_last_d = have_last_q;
    op_cnt_d    = op_cnt_q;
    zero_cnt_d  = zero_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          b_d     = cmd_b;
          // Chaining only takes effect once a result has actually been delivered.
          a_d     = (cmd_chain && have_last_q) ? last_r_q : cmd_a;
          state_d = EXEC;
        end
      end
      EXEC: begin
        r_d     = alu_r;
        zf_d    = alu_zf;
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          last_r_d    = r_q;
          have_last_d = 1'b1;
          op_cnt_d    = sat_inc(op_cnt_q);
          if (zf_q) zero_cnt_d = sat_inc(zero_cnt_q);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      zf_q        <= 1'b0;
      last_r_q    <= '0;
      have_last_q <= 1'b0;
      op_cnt_q    <= '0;
      zero_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      zf_q        <= zf_d;
      last_r_q    <= last_r_d;
      have_last_q <= have_last_d;
      op_cnt_q    <= op_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign res_valid  = (state_q == DONE);
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign res_r      = r_q;
  assign res_zf     = zf_q;
  assign op_count   = op_cnt_q;
  assign zero_count = zero_cnt_q;

endmodule
